// File: rtl/ramsim_arbiter.sv
// Round-robin arbiter/sequencer sharing one RAMsim_DPI port among NREQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT (with timeout) -> RESP.
module ramsim_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*64-1:0] req_addr,
  input  logic [NREQ*64-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    resp_valid,
  output logic               resp_err,
  output logic [63:0]        resp_rdata,
  output logic               rvalid,
  output logic               wvalid,
  output logic [63:0]        raddr,
  output logic [63:0]        waddr,
  output logic [63:0]        wdata,
  input  logic               readReady,
  input  logic               writeReady,
  input  logic               readfin,
  input  logic               writefin,
  input  logic [63:0]        rdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [IW-1:0] r_own;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [63:0]   r_rdata;
  logic          r_err;
  logic [IW-1:0] r_last;
  logic [CW-1:0] r_cnt;

  logic [1:0]    w_state_nxt;
  logic [IW-1:0] w_own_nxt;
  logic          w_we_nxt;
  logic [63:0]   w_addr_nxt;
  logic [63:0]   w_wdata_nxt;
  logic [63:0]   w_rdata_nxt;
  logic          w_err_nxt;
  logic [IW-1:0] w_last_nxt;
  logic [CW-1:0] w_cnt_nxt;

  logic [NREQ-1:0] w_req_ready;
  logic            w_rstrb;
  logic            w_wstrb;
  logic            w_fin;
  logic            w_gnt_found;
  logic [IW-1:0]   w_gnt_idx;
  logic [63:0]     w_addr_arr  [NREQ];
  logic [63:0]     w_wdata_arr [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign w_addr_arr[g]  = req_addr[g*64 +: 64];
    assign w_wdata_arr[g] = req_wdata[g*64 +: 64];
  end

  // Round-robin search starting one past the last owner.
  always_comb begin
    int j;
    j           = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      j = int'(r_last) + i;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      if (!w_gnt_found && req_valid[IW'(j)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = IW'(j);
      end
    end
  end

  // Next-state and combinational strobe logic.
  always_comb begin
    w_state_nxt = r_state;
    w_own_nxt   = r_own;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_req_ready = '0;
    w_rstrb     = 1'b0;
    w_wstrb     = 1'b0;
    w_fin       = r_we ? writefin : readfin;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_found) begin
          w_req_ready = NREQ'(1) << w_gnt_idx;
          w_own_nxt   = w_gnt_idx;
          w_we_nxt    = req_we[w_gnt_idx];
          w_addr_nxt  = w_addr_arr[w_gnt_idx];
          w_wdata_nxt = w_wdata_arr[w_gnt_idx];
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_we ? writeReady : readReady) begin
          w_wstrb     = r_we;
          w_rstrb     = !r_we;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A fin arriving on the timeout cycle still completes normally.
        if (w_fin) begin
          w_rdata_nxt = r_we ? 64'd0 : rdata;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_rdata_nxt = 64'd0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        w_last_nxt  = r_own;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_own   <= '0;
      r_we    <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
      r_last  <= IW'(NREQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_own   <= w_own_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign req_ready  = w_req_ready;
  assign rvalid     = w_rstrb;
  assign wvalid     = w_wstrb;
  assign resp_valid = (r_state == S_RESP) ? (NREQ'(1) << r_own) : '0;
  assign resp_err   = r_err;
  assign resp_rdata = r_rdata;
  assign raddr      = r_addr;
  assign waddr      = r_addr;
  assign wdata      = r_wdata;

endmodule

// File: tb/tb_ramsim_arbiter.sv
// Directed self-checking bench for ramsim_arbiter (NREQ=4, TIMEOUT=8).
module tb_ramsim_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_we;
  logic [255:0] req_addr;
  logic [255:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic         resp_err;
  logic [63:0]  resp_rdata;
  logic         rvalid, wvalid;
  logic [63:0]  raddr, waddr, wdata;
  logic         readReady, writeReady, readfin, writefin;
  logic [63:0]  rdata;

  logic [63:0] tb_addr  [4];
  logic [63:0] tb_wdata [4];

  int n_total = 0;
  int n_bad   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_addr[g*64 +: 64]  = tb_addr[g];
    assign req_wdata[g*64 +: 64] = tb_wdata[g];
  end

  ramsim_arbiter #(.NREQ(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .rvalid(rvalid), .wvalid(wvalid), .raddr(raddr), .waddr(waddr), .wdata(wdata),
    .readReady(readReady), .writeReady(writeReady), .readfin(readfin), .writefin(writefin),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1; req_valid = '0; req_we = '0;
    readReady = 1'b1; writeReady = 1'b1; readfin = 1'b0; writefin = 1'b0; rdata = '0;
    for (int i = 0; i < 4; i++) begin
      tb_addr[i] = 64'h0; tb_wdata[i] = 64'h0;
    end
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_strobes", 64'({rvalid, wvalid}), 64'h0);
    chk("rst_resp", 64'({resp_err}) | resp_rdata, 64'h0);
    chk("rst_addr_data", raddr | waddr | wdata, 64'h0);

    // Single read by requester 0, fin three cycles after the strobe.
    tick();
    tb_addr[0] = 64'h100; req_we[0] = 1'b0; req_valid = 4'b0001;
    #1 chk("rd_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    #1 chk("rd_rvalid", 64'(rvalid), 64'h1);
    chk("rd_raddr", raddr, 64'h100);
    chk("rd_ready_off", 64'(req_ready), 64'h0);
    tick();
    #1 chk("rd_rvalid_once", 64'(rvalid), 64'h0);
    tick();
    tick();
    readfin = 1'b1; rdata = 64'hDEADBEEF;
    tick();
    readfin = 1'b0; rdata = 64'h0;
    #1 chk("rd_resp_valid", 64'(resp_valid), 64'h1);
    chk("rd_resp_rdata", resp_rdata, 64'hDEADBEEF);
    chk("rd_resp_err", 64'(resp_err), 64'h0);
    tick();
    #1 chk("rd_resp_once", 64'(resp_valid), 64'h0);

    // Round-robin: all four hold write requests; grants 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tb_addr[i] = 64'h200 + 64'(i); tb_wdata[i] = 64'h10 + 64'(i);
    end
    req_we = 4'b1111; req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      int e;
      e = t % 4;
      #1 chk("rr_grant", 64'(req_ready), 64'(4'b0001 << e));
      tick();
      if (t == 4) req_valid = 4'b0000;
      #1 chk("rr_wvalid", 64'(wvalid), 64'h1);
      chk("rr_waddr", waddr, 64'h200 + 64'(e));
      chk("rr_wdata", wdata, 64'h10 + 64'(e));
      tick();
      writefin = 1'b1;
      tick();
      writefin = 1'b0;
      #1 chk("rr_resp_valid", 64'(resp_valid), 64'(4'b0001 << e));
      chk("rr_resp_rdata", resp_rdata, 64'h0);
      chk("rr_no_ready_in_resp", 64'(req_ready), 64'h0);
      tick();
    end

    // Backpressure: requester 1 write, writeReady low for five cycles.
    tb_addr[1] = 64'h300; tb_wdata[1] = 64'h55; req_we[1] = 1'b1;
    req_valid = 4'b0010; writeReady = 1'b0;
    #1 chk("bp_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_wvalid_low", 64'(wvalid), 64'h0);
      tick();
    end
    writeReady = 1'b1;
    #1 chk("bp_wvalid_rise", 64'(wvalid), 64'h1);
    chk("bp_wdata", wdata, 64'h55);
    tick();
    writefin = 1'b1;
    tick();
    writefin = 1'b0;
    #1 chk("bp_resp_valid", 64'(resp_valid), 64'h2);
    tick();

    // Timeout: requester 3 read without fin; response 9 cycles after the strobe.
    tb_addr[3] = 64'h400; req_we[3] = 1'b0; req_valid = 4'b1000; rdata = 64'hBAD;
    #1 chk("to_grant", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'b0000;
    #1 chk("to_rvalid", 64'(rvalid), 64'h1);
    seen = 1'b0;
    for (int c = 1; c < 9; c++) begin
      tick();
      if (resp_valid != 4'b0000) seen = 1'b1;
    end
    chk("to_no_early_resp", 64'(seen), 64'h0);
    tick();
    chk("to_resp_valid", 64'(resp_valid), 64'h8);
    chk("to_resp_err", 64'(resp_err), 64'h1);
    chk("to_resp_rdata", resp_rdata, 64'h0);
    tick();
    readfin = 1'b1;
    tick();
    readfin = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (resp_valid != 4'b0000 || rvalid || wvalid) seen = 1'b1;
    end
    chk("to_stale_fin_ignored", 64'(seen), 64'h0);

    // Collision: fin in ISSUE is ignored, fin on the timeout cycle wins.
    tb_addr[0] = 64'h500; req_we[0] = 1'b0; req_valid = 4'b0001;
    #1 chk("col_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000; readfin = 1'b1; rdata = 64'h1111;
    #1 chk("col_rvalid", 64'(rvalid), 64'h1);
    tick();
    readfin = 1'b0; rdata = 64'h0;
    seen = 1'b0;
    for (int w = 0; w < 7; w++) begin
      #1 if (resp_valid != 4'b0000) seen = 1'b1;
      tick();
    end
    chk("col_issue_fin_ignored", 64'(seen), 64'h0);
    readfin = 1'b1; rdata = 64'hCAFEF00D;
    tick();
    readfin = 1'b0; rdata = 64'h0;
    #1 chk("col_resp_valid", 64'(resp_valid), 64'h1);
    chk("col_resp_err", 64'(resp_err), 64'h0);
    chk("col_resp_rdata", resp_rdata, 64'hCAFEF00D);
    tick();

    // Reset during WAIT abandons the write; requester 0 wins afterwards.
    tb_addr[1] = 64'h600; tb_wdata[1] = 64'h77; req_we[1] = 1'b1; req_valid = 4'b0010;
    #1 chk("rw_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("rw_resp_valid", 64'(resp_valid), 64'h0);
    chk("rw_resp_out", 64'({resp_err}) | resp_rdata, 64'h0);
    chk("rw_addr_data", raddr | waddr | wdata, 64'h0);
    chk("rw_strobes", 64'({rvalid, wvalid}), 64'h0);
    tb_addr[0] = 64'h700; tb_addr[2] = 64'h720; req_we[0] = 1'b0; req_we[2] = 1'b0;
    req_valid = 4'b0101;
    #1 chk("rw_grant0_first", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    #1 chk("rw_raddr", raddr, 64'h700);
    chk("rw_no_resp", 64'(resp_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ramsim_arbiter.md
# ramsim_arbiter

Round-robin arbiter and sequencer that shares one RAMsim_DPI memory port among `NREQ` requesters. It accepts one read or write at a time, issues it on the RAMsim read or write channel, waits for completion with a timeout, and returns the result to the owning requester. It sits between the requester-side logic and the RAMsim_DPI instance and is the only driver of that instance's request inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; must be at least 2.
- `TIMEOUT`, 1024: maximum WAIT cycles before a transaction is aborted; must be at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*64  flattened 64-bit addresses; slice i is requester i.
- `req_wdata`  in  NREQ*64  flattened 64-bit write data.
- `req_ready`  out  NREQ  one-hot accept strobe.
- `resp_valid`  out  NREQ  one-hot, one-cycle completion strobe.
- `resp_err`  out  1  qualifies `resp_valid`; 1 = timeout.
- `resp_rdata`  out  64  read data, shared by all requesters.
- `rvalid`, `wvalid`  out  1 each  RAMsim request strobes.
- `raddr`, `waddr`, `wdata`  out  64 each  RAMsim address and data.
- `readReady`, `writeReady`, `readfin`, `writefin`  in  1 each  RAMsim status inputs.
- `rdata`  in  64  RAMsim read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Registers: `own` (index of the winning requester), `we_q`, `addr_q`, `wdata_q`, `rdata_q`, `err_q`, `last`, and `cnt` of width $clog2(TIMEOUT+1).
- IDLE, arbitration:
  - Priority starts at `(last+1) mod NREQ` and wraps.
  - The winner `w` gets `req_ready[w]=1`. This output is combinational and exists only in IDLE.
  - On the same edge: capture `addr_q`, `wdata_q`, `we_q`, set `own=w`, go to ISSUE.
  - With no `req_valid`, stay in IDLE.
- Requester contract:
  - Hold request fields stable until accepted.
  - A requester may drop `req_valid` before it is accepted.
- ISSUE:
  - A read waits for `readReady`; a write waits for `writeReady`.
  - In the cycle the matching ready is high, `rvalid` (read) or `wvalid` (write) is 1. This strobe is combinational from state and ready.
  - On that edge: clear `cnt`, go to WAIT.
  - Without ready, stay in ISSUE with both strobes 0.
- WAIT:
  - A matching fin (`readfin` for a read, `writefin` for a write) completes the transaction:
    - capture `rdata_q = rdata` for a read, or 0 for a write;
    - set `err_q = 0` and go to RESP.
  - Otherwise, if `cnt == TIMEOUT-1`: set `rdata_q = 0`, `err_q = 1`, go to RESP.
  - Otherwise increment `cnt`.
  - If fin and the timeout condition occur in the same cycle, fin wins.
- RESP:
  - Drive `resp_valid[own]=1`, `resp_rdata=rdata_q`, `resp_err=err_q` for one cycle.
  - Set `last=own`, go to IDLE.
- Fin outside WAIT, and a non-matching fin, are ignored. This includes stale fins after a timeout or reset.
- `raddr`, `waddr` and `wdata` continuously drive `addr_q`, `addr_q` and `wdata_q`. Only the strobes qualify them.
- There is no response backpressure; requesters must sink `resp_valid`.

## Timing
- Reset:
  - State IDLE, `last=NREQ-1` (requester 0 has first priority), `cnt=0`.
  - All `q` registers are 0, so every output is 0.
  - A reset in any state abandons the transaction with no response. Requester-side and RAMsim-side recovery is the system's responsibility.
- Latency for an accept at cycle T, with ready high immediately:
  - Strobe at T+1.
  - WAIT begins at T+2.
  - Fin at T+2+k gives `resp_valid` at T+3+k.
  - The next accept is possible at T+4+k.
- Minimum occupancy is 4 cycles per transaction. Only one transaction is outstanding at a time.
- Timeout: with no fin, `resp_valid` (`err=1`) appears `TIMEOUT+1` cycles after the strobe cycle.
- `req_ready` and `resp_valid` never both assert in the same cycle.

## Test plan
- Single read:
  - Stimulus: requester 0 reads 0x100; `readReady=1`; `readfin` 3 cycles after `rvalid` with `rdata`=0xDEADBEEF.
  - Response: one-cycle `rvalid` with `raddr`=0x100; `resp_valid`=4'b0001, `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- Round-robin:
  - Stimulus: all 4 requesters continuously request writes (`wdata`=0x10+i); `writefin` 1 cycle after `wvalid`.
  - Response: grant order 0,1,2,3,0; each `wdata` matches its owner; `resp_rdata`=0.
- Backpressure:
  - Stimulus: a write with `writeReady` low for 5 cycles.
  - Response: FSM stays in ISSUE; `wvalid` is 0 for those cycles; `wvalid` rises in the first cycle `writeReady` is 1.
- Timeout:
  - Stimulus: `TIMEOUT`=8; a read that never gets `readfin`; then `readfin` pulses while IDLE.
  - Response: `resp_valid` with `resp_err`=1 and `resp_rdata`=0 exactly 9 cycles after `rvalid`; the later `readfin` is ignored (no response).
- Fin/timeout collision and ignored fins:
  - Stimulus: `readfin` in the ISSUE cycle and in WAIT cycle `cnt`=TIMEOUT-1.
  - Response: the ISSUE fin is ignored; the second fin completes the read with `resp_err`=0 and real data.
- Reset mid-WAIT:
  - Stimulus: assert `rst` for 1 cycle during WAIT; then requesters 2 and 0 both request.
  - Response: all outputs 0 after the reset edge; no response for the abandoned transaction; requester 0 is granted first.
